// File: rtl/bank_write_sequencer.sv
// Round-robin write sequencer: sample k lands in bank k mod N at row k / N.
// Pulses done together with the final write so the read side can sweep in the same order.
module bank_write_sequencer #(
   parameter  int unsigned MAX_CNT          = 1024,
   parameter  int unsigned DATA_WIDTH       = 16,
   parameter  int unsigned N_REGISTERSBANKS = 8,
   localparam int unsigned BANK_WIDTH       = $clog2(N_REGISTERSBANKS),
   localparam int unsigned N_ROWS           = MAX_CNT / N_REGISTERSBANKS,
   localparam int unsigned ADDR_WIDTH       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
   localparam int unsigned CNT_WIDTH        = $clog2(MAX_CNT + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        in_ready,
   output logic [N_REGISTERSBANKS-1:0] wr_en,
   output logic [ADDR_WIDTH-1:0]       wr_addr,
   output logic [DATA_WIDTH-1:0]       wr_data,
   output logic                        busy,
   output logic                        done,
   output logic [CNT_WIDTH-1:0]        count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [BANK_WIDTH-1:0]       bank_idx_q, bank_idx_d;
   logic [ADDR_WIDTH-1:0]       row_q, row_d;
   logic [CNT_WIDTH-1:0]        count_q, count_d;
   logic [N_REGISTERSBANKS-1:0] wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
   logic                        done_q, done_d;

   logic accept;
   logic last_sample;
   logic last_bank;

   // Ready depends on state alone, so there is no path from in_valid to in_ready.
   assign in_ready    = (state_q == FILL);
   assign accept      = in_valid && in_ready;
   assign last_sample = (count_q == CNT_WIDTH'(MAX_CNT - 1));
   assign last_bank   = (bank_idx_q == BANK_WIDTH'(N_REGISTERSBANKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bank_idx_q <= '0;
         row_q      <= '0;
         count_q    <= '0;
         wr_en_q    <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bank_idx_q <= bank_idx_d;
         row_q      <= row_d;
         count_q    <= count_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bank_idx_d = bank_idx_q;
      row_d      = row_q;
      count_d    = count_q;
      wr_en_d    = '0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = FILL;
               bank_idx_d = '0;
               row_d      = '0;
               count_d    = '0;
            end
         end

         FILL: begin
            if (accept) begin
               wr_en_d[bank_idx_q] = 1'b1;
               wr_addr_d           = row_q;
               wr_data_d           = in_data;
               count_d             = count_q + CNT_WIDTH'(1);
               // The final accept parks the indices instead of stepping past the last row.
               if (last_sample) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  bank_idx_d = '0;
                  row_d      = '0;
               end else if (last_bank) begin
                  bank_idx_d = '0;
                  row_d      = row_q + ADDR_WIDTH'(1);
               end else begin
                  bank_idx_d = bank_idx_q + BANK_WIDTH'(1);
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign done    = done_q;
   assign count   = count_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bank_write_sequencer.sv
// Self-checking bench: scoreboarded fills on the default configuration and a
// vector table on a 2-bank, 4-sample instance.
module tb_bank_write_sequencer;

   localparam int unsigned MAX = 1024;
   localparam int unsigned NB  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        start, in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [7:0]  wr_en;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;
   logic        busy, done;
   logic [10:0] count;

   logic        s_start, s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic [1:0]  s_wr_en;
   logic [0:0]  s_wr_addr;
   logic [15:0] s_wr_data;
   logic        s_busy, s_done;
   logic [2:0]  s_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic        start;
      logic        valid;
      logic [15:0] data;
      logic        exp_ready;
      logic [1:0]  exp_wr_en;
      logic        exp_addr;
      logic [15:0] exp_data;
      logic        exp_busy;
      logic        exp_done;
      logic [2:0]  exp_count;
   } vec_t;

   vec_t vecs[10];

   bank_write_sequencer #(
      .MAX_CNT(1024),
      .DATA_WIDTH(16),
      .N_REGISTERSBANKS(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .count(count)
   );

   bank_write_sequencer #(
      .MAX_CNT(4),
      .DATA_WIDTH(16),
      .N_REGISTERSBANKS(2)
   ) dut_small (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_data(s_data),
      .in_ready(s_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .busy(s_busy), .done(s_done), .count(s_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
      chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
      chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
      chk({tag, "_count"},    32'(count),    32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   // Starts a fill and feeds samples data=k; every write is checked against k.
   task automatic run_fill(input string tag, input bit rand_gaps,
                           input int unsigned abort_after, input int unsigned start_at);
      int unsigned k      = 0;
      int unsigned cycles = 0;
      int unsigned writes = 0;
      bit          extra  = 1'b0;
      logic        v;
      start = 1'b1;
      step;
      start = 1'b0;
      chk({tag, "_start_busy"},  32'(busy),     32'd1);
      chk({tag, "_start_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_start_count"}, 32'(count),    32'd0);
      chk({tag, "_start_wr_en"}, 32'(wr_en),    32'd0);
      while (k < MAX && cycles < 6000) begin
         if (abort_after != 0 && k == abort_after) break;
         v        = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         in_data  = 16'(k);
         if (start_at != 0 && k == start_at && !extra) begin
            start = 1'b1;
            extra = 1'b1;
         end
         chk({tag, "_ready"}, 32'(in_ready), 32'd1);
         step;
         start = 1'b0;
         if (wr_en != 8'h00) writes++;
         if (v) begin
            chk({tag, "_wr_en"},   32'(wr_en),   32'(8'(1) << (k % NB)));
            chk({tag, "_wr_addr"}, 32'(wr_addr), k / NB);
            chk({tag, "_wr_data"}, 32'(wr_data), k & 32'hFFFF);
            k++;
         end else begin
            chk({tag, "_idle_wr_en"}, 32'(wr_en), 32'd0);
         end
         chk({tag, "_count"}, 32'(count), k);
         chk({tag, "_done"},  32'(done),  32'(v && (k == MAX)));
         cycles++;
      end
      in_valid = 1'b0;
      chk({tag, "_accepted"}, k, (abort_after != 0) ? abort_after : MAX);
      chk({tag, "_pulses"}, writes, k);
   endtask

   task automatic post_done(input string tag);
      chk({tag, "_done_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_done_busy"},  32'(busy),     32'd1);
      step;
      chk({tag, "_hold_busy"},  32'(busy),     32'd0);
      chk({tag, "_hold_done"},  32'(done),     32'd0);
      chk({tag, "_hold_wr_en"}, 32'(wr_en),    32'd0);
      chk({tag, "_hold_count"}, 32'(count),    MAX);
      chk({tag, "_hold_addr"},  32'(wr_addr),  32'd127);
      chk({tag, "_hold_data"},  32'(wr_data),  32'd1023);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      s_start  = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;

      //            start valid data      rdy en     a  data      busy done cnt
      vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0};
      vecs[1] = '{1'b0, 1'b1, 16'h00A0, 1'b1, 2'b01, 1'b0, 16'h00A0, 1'b1, 1'b0, 3'd1};
      vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h00A0, 1'b1, 1'b0, 3'd1};
      vecs[3] = '{1'b0, 1'b1, 16'h00A1, 1'b1, 2'b10, 1'b0, 16'h00A1, 1'b1, 1'b0, 3'd2};
      vecs[4] = '{1'b0, 1'b1, 16'h00A2, 1'b1, 2'b01, 1'b1, 16'h00A2, 1'b1, 1'b0, 3'd3};
      vecs[5] = '{1'b1, 1'b1, 16'h00A3, 1'b0, 2'b10, 1'b1, 16'h00A3, 1'b1, 1'b1, 3'd4};
      vecs[6] = '{1'b1, 1'b1, 16'h00FF, 1'b0, 2'b00, 1'b1, 16'h00A3, 1'b0, 1'b0, 3'd4};
      vecs[7] = '{1'b0, 1'b1, 16'h00EE, 1'b0, 2'b00, 1'b1, 16'h00A3, 1'b0, 1'b0, 3'd4};
      vecs[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 16'h00A3, 1'b1, 1'b0, 3'd0};
      vecs[9] = '{1'b0, 1'b1, 16'h00B0, 1'b1, 2'b01, 1'b0, 16'h00B0, 1'b1, 1'b0, 3'd1};

      // Reset asserted between clock edges must clear outputs immediately.
      #2 rst = 1'b1;
      #1 chk_zero("rst_async");
      @(negedge clk) rst = 1'b0;
      step;
      chk_zero("rst_release");

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h5A5A + 16'(i);
         chk("idle_ready", 32'(in_ready), 32'd0);
         step;
         chk("idle_wr_en", 32'(wr_en), 32'd0);
         chk("idle_count", 32'(count), 32'd0);
      end
      in_valid = 1'b0;

      run_fill("full", 1'b0, 0, 0);
      post_done("full");

      run_fill("gaps", 1'b1, 0, 0);
      post_done("gaps");

      run_fill("abort", 1'b1, 37, 0);
      #2 rst = 1'b1;
      #1 chk_zero("rst_midfill");
      @(negedge clk) rst = 1'b0;
      step;
      chk("rst_midfill_wr_en", 32'(wr_en), 32'd0);
      run_fill("refill", 1'b0, 0, 0);
      post_done("refill");

      run_fill("ign_start", 1'b0, 0, 100);
      chk("done_cycle_done", 32'(done), 32'd1);
      start = 1'b1;
      step;
      start = 1'b0;
      chk("done_start_busy",  32'(busy),     32'd0);
      chk("done_start_ready", 32'(in_ready), 32'd0);
      chk("done_start_count", 32'(count),    MAX);
      start = 1'b1;
      step;
      start = 1'b0;
      chk("restart_busy",  32'(busy),     32'd1);
      chk("restart_ready", 32'(in_ready), 32'd1);
      chk("restart_count", 32'(count),    32'd0);

      for (int i = 0; i < 10; i++) begin
         s_start = vecs[i].start;
         s_valid = vecs[i].valid;
         s_data  = vecs[i].data;
         step;
         chk($sformatf("vec%0d_ready", i), 32'(s_ready),   32'(vecs[i].exp_ready));
         chk($sformatf("vec%0d_wr_en", i), 32'(s_wr_en),   32'(vecs[i].exp_wr_en));
         chk($sformatf("vec%0d_addr", i),  32'(s_wr_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("vec%0d_data", i),  32'(s_wr_data), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d_busy", i),  32'(s_busy),    32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_done", i),  32'(s_done),    32'(vecs[i].exp_done));
         chk($sformatf("vec%0d_count", i), 32'(s_count),   32'(vecs[i].exp_count));
      end
      s_start = 1'b0;
      s_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
